opsum_packer: RTL and testbench
===============================

OPSUM_PACKER -- requirements
Module: opsum_packer

Interface
REQ-001 The block SHALL have parameter NUM_LANE, default 32, meaning the number of reducer output lanes.
REQ-002 The block SHALL have parameter PSUM_W, default 16, meaning the width of one lane's partial sum.
REQ-003 The block SHALL have parameter DW_LANE, default 10, meaning the number of valid lanes in a DEPTHWISE layer.
REQ-004 Port: clk  input  1  single clock; all logic rises on posedge clk.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port: layer_type  input  1  `POINTWISE/`DEPTHWISE encoding from define.svh, sampled at capture.
REQ-007 Port: relu_en  input  1  when 1, ReLU clamp is applied at capture.
REQ-008 Port: psum_valid  input  1  final_psum holds a valid result vector.
REQ-009 Port: psum_ready  output  1  block accepts a vector this cycle.
REQ-010 Port: final_psum  input  [NUM_LANE-1:0][PSUM_W-1:0]  reducer output, two's complement.
REQ-011 Port: opsum_valid  output  1  opsum_data holds a valid word.
REQ-012 Port: opsum_ready  input  1  downstream accepts the word.
REQ-013 Port: opsum_data  output  2*PSUM_W  packed word {lane[2k+1], lane[2k]}.
REQ-014 Port: opsum_last  output  1  high with the final word of a vector.

Function
REQ-015 The FSM SHALL have two states: IDLE and DRAIN.
REQ-016 Capture SHALL occur on a posedge with psum_valid && psum_ready; at capture the block latches all NUM_LANE lanes, layer_type and relu_en.
REQ-017 When relu_en is 1, a lane with bit PSUM_W-1 set SHALL be stored as 0; otherwise each lane is stored unchanged.
REQ-018 Capture SHALL move the FSM to DRAIN and clear word counter cnt to 0; opsum_valid rises in the next cycle (capture-to-first-word latency 1).
REQ-019 Word count N SHALL be NUM_LANE/2 (16) for `POINTWISE and DW_LANE/2 (5) for `DEPTHWISE; lanes at or above DW_LANE are never emitted in DEPTHWISE.
REQ-020 In DRAIN, opsum_valid SHALL be 1 and opsum_data SHALL be {lane[2*cnt+1], lane[2*cnt]}; in IDLE, opsum_valid=0 and opsum_data=0.
REQ-021 opsum_last SHALL be 1 iff DRAIN and cnt==N-1.
REQ-022 cnt SHALL increment only on opsum_valid && opsum_ready; opsum_data and opsum_last are held stable while opsum_ready=0.
REQ-023 On the handshake with opsum_last=1, the FSM SHALL return to IDLE unless a new capture occurs in the same cycle.
REQ-024 psum_ready SHALL equal (IDLE) || (DRAIN && opsum_last && opsum_ready), combinationally; simultaneous last-word handshake and capture SHALL reload the buffer, keep DRAIN, and set cnt=0 with no bubble.
REQ-025 psum_valid while psum_ready=0 SHALL be ignored; upstream holds the vector.
REQ-026 psum_ready SHALL be 0 while rst_n=0.

Reset
REQ-027 On a posedge with rst_n=0: state=IDLE, cnt=0, lane buffer all 0, latched layer_type=`POINTWISE, latched relu_en=0.
REQ-028 Reset outputs SHALL be opsum_valid=0, opsum_data=0, opsum_last=0, psum_ready=0; psum_ready is 1 in the first cycle after rst_n rises.
REQ-029 A reset during DRAIN SHALL abort the vector; no further words from it are emitted.

Structure
REQ-030 NUM_LANE, PSUM_W, DW_LANE and the POINTWISE/DEPTHWISE encodings SHALL live in the shared accelerator package/define.svh, not be redefined locally.
REQ-031 The block SHALL be a single module with no sub-module; packing and ReLU are inline, and the buffer is one NUM_LANE x PSUM_W register array.

Verification
REQ-032 POINTWISE, relu_en=0, lane[i]=i, opsum_ready=1 -> 16 words on consecutive cycles, word k = {2k+1, 2k}, last on k=15, first word 1 cycle after capture.
REQ-033 DEPTHWISE, lane[i]=100+i -> exactly 5 words; word 4 = {109, 108} with last=1; lanes 10-31 never appear.
REQ-034 relu_en=1, lane0=16'hFFF6, lane1=16'h0007 -> word0 = 32'h0007_0000.
REQ-035 opsum_ready toggled 1,0,0,1 during DRAIN -> data and last held during the stall; no word skipped or duplicated; total 16 words.
REQ-036 psum_valid held high across two vectors, opsum_ready=1 -> psum_ready pulses on the last word of vector A; vector B word0 is emitted the cycle after A's last word (no gap).
REQ-037 rst_n=0 for 1 cycle at cnt=7 -> next cycle opsum_valid=0 and psum_ready=0; after release, psum_ready=1 and a new vector starts at word 0.

Source files
------------

// File: rtl/opsum_packer_pkg.sv
// rtl/opsum_packer_pkg.sv - shared accelerator constants and types for the output-sum packer
//
// Purpose: holds the lane geometry and layer-type encodings shared across the
// accelerator, plus the packer FSM state type.
package opsum_packer_pkg;

  // Reducer geometry
  localparam int OPS_NUM_LANE = 32;  // reducer output lanes
  localparam int OPS_PSUM_W   = 16;  // partial-sum width per lane
  localparam int OPS_DW_LANE  = 10;  // valid lanes in a depthwise layer

  // Layer-type encodings
  localparam logic POINTWISE = 1'b0;
  localparam logic DEPTHWISE = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } opsum_state_t;

endpackage

// File: rtl/opsum_packer.sv
// rtl/opsum_packer.sv - captures a reducer result vector and streams it out two lanes per word
//
// Purpose: latches NUM_LANE partial sums (optionally ReLU-clamped) on a
// psum_valid/psum_ready handshake, then emits them as {lane[2k+1], lane[2k]}
// words on the opsum stream. Pointwise layers emit NUM_LANE/2 words,
// depthwise layers emit DW_LANE/2 words. A new vector may be captured on the
// same cycle the last word is accepted, giving back-to-back output.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   layer_type   in   POINTWISE/DEPTHWISE, sampled at capture
//   relu_en      in   clamp negative lanes to 0 at capture
//   psum_valid   in   final_psum holds a valid vector
//   psum_ready   out  vector accepted this cycle
//   final_psum   in   NUM_LANE x PSUM_W two's-complement lanes
//   opsum_valid  out  opsum_data holds a valid word
//   opsum_ready  in   downstream accepts the word
//   opsum_data   out  {lane[2k+1], lane[2k]}
//   opsum_last   out  final word of the vector
module opsum_packer
  import opsum_packer_pkg::*;
#(
  parameter int NUM_LANE = OPS_NUM_LANE,
  parameter int PSUM_W   = OPS_PSUM_W,
  parameter int DW_LANE  = OPS_DW_LANE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             layer_type,
  input  logic                             relu_en,
  input  logic                             psum_valid,
  output logic                             psum_ready,
  input  logic [NUM_LANE-1:0][PSUM_W-1:0]  final_psum,
  output logic                             opsum_valid,
  input  logic                             opsum_ready,
  output logic [2*PSUM_W-1:0]              opsum_data,
  output logic                             opsum_last
);

  localparam int PW_WORDS = NUM_LANE / 2;
  localparam int DW_WORDS = DW_LANE / 2;
  localparam int CNT_W    = (PW_WORDS > 1) ? $clog2(PW_WORDS) : 1;
  localparam int IDX_W    = CNT_W + 1;

  opsum_state_t            state;
  logic [CNT_W-1:0]        cnt;
  logic                    layer_q;
  logic [PSUM_W-1:0]       lane_buf [NUM_LANE];

  logic [CNT_W-1:0]        last_cnt;
  logic                    drain;
  logic                    word_last;
  logic                    capture;
  logic                    take;
  logic [IDX_W-1:0]        idx_lo;
  logic [IDX_W-1:0]        idx_hi;

  assign drain     = (state == ST_DRAIN);
  assign last_cnt  = (layer_q == DEPTHWISE) ? CNT_W'(DW_WORDS - 1) : CNT_W'(PW_WORDS - 1);
  assign word_last = drain && (cnt == last_cnt);
  assign take      = drain && opsum_ready;

  // Ready while idle, or on the cycle the last word leaves so the next vector
  // follows without a bubble. Forced low during reset.
  assign psum_ready = rst_n && (!drain || (word_last && opsum_ready));
  assign capture    = psum_valid && psum_ready;

  assign idx_lo = {cnt, 1'b0};
  assign idx_hi = {cnt, 1'b1};

  assign opsum_valid = drain;
  assign opsum_last  = word_last;
  assign opsum_data  = drain ? {lane_buf[idx_hi], lane_buf[idx_lo]} : '0;

  // The ReLU decision is folded into the buffer contents at capture, so the
  // relu_en setting needs no storage of its own beyond the clamped lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      layer_q <= POINTWISE;
      for (int i = 0; i < NUM_LANE; i++) begin
        lane_buf[i] <= '0;
      end
    end else if (capture) begin
      state   <= ST_DRAIN;
      cnt     <= '0;
      layer_q <= layer_type;
      for (int i = 0; i < NUM_LANE; i++) begin
        lane_buf[i] <= (relu_en && final_psum[i][PSUM_W-1]) ? '0 : final_psum[i];
      end
    end else if (take) begin
      if (word_last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_opsum_packer.sv
// tb/tb_opsum_packer.sv - directed self-checking bench for opsum_packer
module tb_opsum_packer;
  import opsum_packer_pkg::*;

  localparam int NL = 32;
  localparam int PW = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   layer_type;
  logic                   relu_en;
  logic                   psum_valid;
  logic                   psum_ready;
  logic [NL-1:0][PW-1:0]  final_psum;
  logic                   opsum_valid;
  logic                   opsum_ready;
  logic [2*PW-1:0]        opsum_data;
  logic                   opsum_last;

  logic [PW-1:0]          lanes   [NL];
  logic [PW-1:0]          exp_lane[NL];
  int                     n_cmp;
  int                     n_fail;

  opsum_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .layer_type  (layer_type),
    .relu_en     (relu_en),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .final_psum  (final_psum),
    .opsum_valid (opsum_valid),
    .opsum_ready (opsum_ready),
    .opsum_data  (opsum_data),
    .opsum_last  (opsum_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present lanes[] upstream and build the expected stored lanes.
  task automatic present(input logic lt, input logic re);
    for (int i = 0; i < NL; i++) begin
      final_psum[i] = lanes[i];
      exp_lane[i]   = (re && lanes[i][PW-1]) ? '0 : lanes[i];
    end
    layer_type = lt;
    relu_en    = re;
    psum_valid = 1'b1;
  endtask

  // Capture a vector; on return (negedge + 1) word 0 should be visible.
  task automatic capture_vec(input string tag, input logic lt, input logic re);
    present(lt, re);
    #1;
    chk({tag, "_cap_ready"}, psum_ready, 1);
    chk({tag, "_cap_idle"}, opsum_valid, 0);
    @(negedge clk);
    psum_valid = 1'b0;
    #1;
  endtask

  // With opsum_ready=1, expect n consecutive words then IDLE.
  task automatic drain_words(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_v%0d", tag, k), opsum_valid, 1);
      chk($sformatf("%s_d%0d", tag, k), opsum_data, {exp_lane[2*k+1], exp_lane[2*k]});
      chk($sformatf("%s_l%0d", tag, k), opsum_last, (k == n - 1));
      @(negedge clk);
      #1;
    end
    chk({tag, "_end_valid"}, opsum_valid, 0);
    chk({tag, "_end_data"}, opsum_data, 0);
    chk({tag, "_end_ready"}, psum_ready, 1);
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    layer_type  = POINTWISE;
    relu_en     = 1'b0;
    psum_valid  = 1'b0;
    opsum_ready = 1'b1;
    final_psum  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", opsum_valid, 0);
    chk("rst_data", opsum_data, 0);
    chk("rst_last", opsum_last, 0);
    chk("rst_ready", psum_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", psum_ready, 1);

    // Pointwise, lane[i]=i
    for (int i = 0; i < NL; i++) lanes[i] = PW'(i);
    capture_vec("pw", POINTWISE, 1'b0);
    chk("pw_w0_const", opsum_data, 32'h0001_0000);
    drain_words("pw", 16);

    // Depthwise, lane[i]=100+i: five words only
    for (int i = 0; i < NL; i++) lanes[i] = PW'(100 + i);
    capture_vec("dw", DEPTHWISE, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1;
    end
    chk("dw_w4_const", opsum_data, {16'd109, 16'd108});
    chk("dw_w4_last", opsum_last, 1);
    @(negedge clk);
    #1;
    chk("dw_after_valid", opsum_valid, 0);

    for (int i = 0; i < NL; i++) lanes[i] = PW'(100 + i);
    capture_vec("dw2", DEPTHWISE, 1'b0);
    drain_words("dw2", 5);

    // ReLU clamp
    for (int i = 0; i < NL; i++) lanes[i] = (i % 3 == 0) ? PW'(-i) : PW'(i);
    lanes[0] = 16'hFFF6;
    lanes[1] = 16'h0007;
    capture_vec("relu", POINTWISE, 1'b1);
    chk("relu_w0_const", opsum_data, 32'h0007_0000);
    drain_words("relu", 16);

    // Backpressure 1,0,0,1 with negative lanes and relu off
    for (int i = 0; i < NL; i++) lanes[i] = 16'h8000 + PW'(3 * i);
    capture_vec("stall", POINTWISE, 1'b0);
    begin
      int k;
      int c;
      logic [3:0] pat;
      pat = 4'b1001;
      k = 0;
      c = 0;
      while (k < 16 && c < 200) begin
        opsum_ready = pat[3 - (c % 4)];
        #1;
        chk($sformatf("stall_v%0d", c), opsum_valid, 1);
        chk($sformatf("stall_d%0d", c), opsum_data, {exp_lane[2*k+1], exp_lane[2*k]});
        chk($sformatf("stall_l%0d", c), opsum_last, (k == 15));
        if (opsum_ready) k++;
        c++;
        @(negedge clk);
      end
      chk("stall_words", k, 16);
      opsum_ready = 1'b1;
      #1;
      chk("stall_end_valid", opsum_valid, 0);
    end

    // Back-to-back: psum_valid held across vector A and B
    for (int i = 0; i < NL; i++) lanes[i] = PW'(200 + i);
    present(POINTWISE, 1'b0);
    #1;
    chk("b2b_cap_ready", psum_ready, 1);
    @(negedge clk);
    for (int i = 0; i < NL; i++) lanes[i] = PW'(300 + i);
    present(DEPTHWISE, 1'b0);
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b2b_a_d%0d", k), opsum_data, {PW'(201 + 2 * k), PW'(200 + 2 * k)});
      chk($sformatf("b2b_a_l%0d", k), opsum_last, (k == 15));
      chk($sformatf("b2b_a_r%0d", k), psum_ready, (k == 15));
      @(negedge clk);
      #1;
    end
    psum_valid = 1'b0;
    chk("b2b_b_w0_const", opsum_data, {16'd301, 16'd300});
    drain_words("b2b_b", 5);

    // Reset mid-drain at cnt=7
    for (int i = 0; i < NL; i++) lanes[i] = PW'(i);
    capture_vec("rmid", POINTWISE, 1'b0);
    repeat (7) begin
      @(negedge clk);
      #1;
    end
    chk("rmid_w7", opsum_data, 32'h000F_000E);
    rst_n = 1'b0;
    #1;
    chk("rmid_ready_low", psum_ready, 0);
    @(posedge clk);
    #1;
    chk("rmid_valid", opsum_valid, 0);
    chk("rmid_data", opsum_data, 0);
    chk("rmid_ready", psum_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmid_rel_ready", psum_ready, 1);
    for (int i = 0; i < NL; i++) lanes[i] = PW'(50 + i);
    capture_vec("rnew", POINTWISE, 1'b0);
    chk("rnew_w0_const", opsum_data, {16'd51, 16'd50});
    drain_words("rnew", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
